char_cursor_ctrl: RTL and testbench

- Sequencer for the character overlay datapath of the display controller.
- Owns the character position (posx/posy), glyph select (chr), glyph enable (chr_a), blink and colour (rgb) that feed the display controller.
- Updates motion only at frame boundaries, detected from the display controller's vsync, so the glyph never tears mid-frame.
- Screen is 640x480; glyph is 8x16.

---
 rtl/char_cursor_ctrl_if.sv | 29 ++
 rtl/char_cursor_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_char_cursor_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/char_cursor_ctrl_if.sv
// Button/vsync inputs and glyph overlay outputs shared between the
// cursor controller (slave) and the display/panel side (master).
interface char_cursor_ctrl_if;
  logic       vsync;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_chr;
  logic       btn_col;
  logic       blink_en;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [1:0] chr;
  logic       chr_a;
  logic [8:0] rgb;
  logic       blink;
  logic       frame_tick;

  modport master (
    output vsync, btn_up, btn_down, btn_left, btn_right, btn_chr, btn_col, blink_en,
    input  posx, posy, chr, chr_a, rgb, blink, frame_tick
  );

  modport slave (
    input  vsync, btn_up, btn_down, btn_left, btn_right, btn_chr, btn_col, blink_en,
    output posx, posy, chr, chr_a, rgb, blink, frame_tick
  );
endinterface

// File: rtl/char_cursor_ctrl.sv
// Character overlay sequencer: frame-synchronous cursor motion with auto-repeat,
// glyph/colour select and blink. Define CURSOR_WRAP_EN to wrap at screen edges.
module char_cursor_ctrl #(
  parameter int unsigned X_INIT       = 312,
  parameter int unsigned Y_INIT       = 232,
  parameter int unsigned X_MAX        = 632,
  parameter int unsigned Y_MAX        = 464,
  parameter int unsigned STEP         = 8,
  parameter int unsigned HOLD_FRAMES  = 10,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic               clk,
  input logic               reset,
  char_cursor_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [9:0]  Y_MAX_S    = 10'(Y_MAX);
  localparam logic signed [10:0] STEP_X     = 11'(STEP);
  localparam logic signed [9:0]  STEP_Y     = 10'(STEP);
  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]         BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // bit order: vsync, up, down, left, right, chr, col
  logic [6:0] raw, s1, s2, s3;
  assign raw = {bus.vsync, bus.btn_up, bus.btn_down, bus.btn_left,
                bus.btn_right, bus.btn_chr, bus.btn_col};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic vsync_fall, chr_rise, col_rise;
  logic up, down, left, right, held;
  assign vsync_fall = s3[6] & ~s2[6];
  assign up         = s2[5];
  assign down       = s2[4];
  assign left       = s2[3];
  assign right      = s2[2];
  assign chr_rise   = s2[1] & ~s3[1];
  assign col_rise   = s2[0] & ~s3[0];
  assign held       = (right ^ left) | (down ^ up);

  state_t             state, state_n;
  logic [7:0]         hold_cnt, hold_cnt_n, hold_inc;
  logic               step_en;
  logic               frame_tick;
  logic [9:0]         posx;
  logic [8:0]         posy;
  logic signed [10:0] dx, x_sum;
  logic signed [9:0]  dy, y_sum;
  logic [9:0]         x_next;
  logic [8:0]         y_next;

  assign hold_inc = hold_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (frame_tick) begin
      unique case (state)
        IDLE:    if (held) state_n = PRESS;
        PRESS:   if (!held) state_n = IDLE;
                 else if (hold_inc == HOLD_LAST) state_n = REPEAT;
        REPEAT:  if (!held) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    step_en    = 1'b0;
    hold_cnt_n = hold_cnt;
    if (frame_tick && held) begin
      unique case (state)
        IDLE:    begin step_en = 1'b1; hold_cnt_n = '0; end
        PRESS:   hold_cnt_n = hold_inc;
        REPEAT:  step_en = 1'b1;
        default: hold_cnt_n = '0;
      endcase
    end
  end

  always_comb begin
    dx = '0;
    dy = '0;
    if (right && !left)      dx = STEP_X;
    else if (left && !right) dx = -STEP_X;
    if (down && !up)         dy = STEP_Y;
    else if (up && !down)    dy = -STEP_Y;
    x_sum = $signed({1'b0, posx}) + dx;
    y_sum = $signed({1'b0, posy}) + dy;
`ifdef CURSOR_WRAP_EN
    if (x_sum < 0)            x_next = X_MAX_S[9:0];
    else if (x_sum > X_MAX_S) x_next = '0;
    else                      x_next = x_sum[9:0];
    if (y_sum < 0)            y_next = Y_MAX_S[8:0];
    else if (y_sum > Y_MAX_S) y_next = '0;
    else                      y_next = y_sum[8:0];
`else
    if (x_sum < 0)            x_next = '0;
    else if (x_sum > X_MAX_S) x_next = X_MAX_S[9:0];
    else                      x_next = x_sum[9:0];
    if (y_sum < 0)            y_next = '0;
    else if (y_sum > Y_MAX_S) y_next = Y_MAX_S[8:0];
    else                      y_next = y_sum[8:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      posx       <= 10'(X_INIT);
      posy       <= 9'(Y_INIT);
      frame_tick <= 1'b0;
    end else begin
      hold_cnt   <= hold_cnt_n;
      frame_tick <= vsync_fall;
      if (step_en) begin
        posx <= x_next;
        posy <= y_next;
      end
    end
  end

  logic [1:0] chr;
  logic       chr_a;
  logic [2:0] pal_idx;
  logic [8:0] pal_rgb, rgb;
  logic       blink;
  logic [7:0] blink_cnt;

  always_comb begin
    unique case (pal_idx)
      3'd0: pal_rgb = 9'h1FF;
      3'd1: pal_rgb = 9'h1C0;
      3'd2: pal_rgb = 9'h038;
      3'd3: pal_rgb = 9'h007;
      3'd4: pal_rgb = 9'h1F8;
      3'd5: pal_rgb = 9'h03F;
      3'd6: pal_rgb = 9'h1C7;
      default: pal_rgb = 9'h092;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chr     <= '0;
      chr_a   <= 1'b0;
      pal_idx <= '0;
      rgb     <= 9'h1FF;
    end else begin
      if (chr_rise)   chr     <= chr + 2'd1;
      if (frame_tick) chr_a   <= 1'b1;
      if (col_rise)   pal_idx <= pal_idx + 3'd1;
      rgb <= pal_rgb;
    end
  end

  // blink_en is a level control sampled directly so dropping it forces blink on the next edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (!bus.blink_en) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  assign bus.posx       = posx;
  assign bus.posy       = posy;
  assign bus.chr        = chr;
  assign bus.chr_a      = chr_a;
  assign bus.rgb        = rgb;
  assign bus.blink      = blink;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_char_cursor_ctrl.sv
// Directed bench for char_cursor_ctrl: default instance plus a second instance
// parked near the screen edges for boundary stepping.
module tb_char_cursor_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  char_cursor_ctrl_if ia();
  char_cursor_ctrl_if ib();

  char_cursor_ctrl dut_a (.clk(clk), .reset(reset), .bus(ia));

  char_cursor_ctrl #(.X_INIT(4), .Y_INIT(456)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    ia.vsync = 1'b0;
    ib.vsync = 1'b0;
    tick(4);
    ia.vsync = 1'b1;
    ib.vsync = 1'b1;
    tick(4);
  endtask

  task automatic set_a(input logic u, input logic d, input logic l, input logic r);
    ia.btn_up = u; ia.btn_down = d; ia.btn_left = l; ia.btn_right = r;
  endtask

  task automatic set_b(input logic u, input logic d, input logic l, input logic r);
    ib.btn_up = u; ib.btn_down = d; ib.btn_left = l; ib.btn_right = r;
  endtask

  logic [1:0]  chr_exp [5];
  logic [8:0]  rgb_exp [8];
  logic [31:0] x_exp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chr_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rgb_exp  = '{9'h1C0, 9'h038, 9'h007, 9'h1F8, 9'h03F, 9'h1C7, 9'h092, 9'h1FF};
    reset = 1'b0;
    ia.vsync = 1'b1; ib.vsync = 1'b1;
    ia.blink_en = 1'b0; ib.blink_en = 1'b0;
    ia.btn_chr = 1'b0; ia.btn_col = 1'b0; ib.btn_chr = 1'b0; ib.btn_col = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick(3);

    check("rst_posx", ia.posx, 312);
    check("rst_posy", ia.posy, 232);
    check("rst_chr", ia.chr, 0);
    check("rst_chr_a", ia.chr_a, 0);
    check("rst_rgb", ia.rgb, 9'h1FF);
    check("rst_blink", ia.blink, 1);
    check("rst_ftick", ia.frame_tick, 0);
    reset = 1'b1;
    tick(4);

    // first frame: tick 3 clk after vsync falls, one cycle wide
    ia.vsync = 1'b0; ib.vsync = 1'b0;
    tick(2);
    check("ftick_early", ia.frame_tick, 0);
    tick(1);
    check("ftick_lat3", ia.frame_tick, 1);
    tick(1);
    check("ftick_width", ia.frame_tick, 0);
    ia.vsync = 1'b1; ib.vsync = 1'b1;
    tick(4);
    check("f1_chr_a", ia.chr_a, 1);
    check("f1_posx", ia.posx, 312);
    check("f1_posy", ia.posy, 232);
    check("f1_rgb", ia.rgb, 9'h1FF);
    check("f1_blink", ia.blink, 1);

    // hold right for 15 frames
    set_a(0, 0, 0, 1);
    for (int f = 1; f <= 15; f++) begin
      frame();
      x_exp = (f <= 10) ? 32'd320 : 32'(320 + 8 * (f - 10));
      check($sformatf("hold_r_f%0d", f), ia.posx, x_exp);
    end
    set_a(0, 0, 0, 0);
    frame();
    check("rel_posx", ia.posx, 360);
    set_a(0, 0, 0, 1);
    frame();
    check("repress_step", ia.posx, 368);
    frame();
    check("repress_press", ia.posx, 368);
    set_a(0, 0, 0, 0);
    frame();

    // left+right cancel, down moves
    set_a(0, 1, 1, 1);
    frame();
    check("lrd_posx", ia.posx, 368);
    check("lrd_posy", ia.posy, 240);
    frame();
    check("lrd_hold_posy", ia.posy, 240);
    set_a(0, 0, 0, 0);
    frame();
    set_a(1, 0, 1, 0);
    frame();
    check("diag_posx", ia.posx, 360);
    check("diag_posy", ia.posy, 232);
    set_a(0, 0, 0, 0);
    frame();

    // press and release between frame ticks is ignored
    set_a(0, 0, 0, 1);
    tick(5);
    set_a(0, 0, 0, 0);
    tick(5);
    frame();
    check("glitch_posx", ia.posx, 360);

    // reset mid-hold
    set_a(0, 0, 0, 1);
    frame();
    check("pre_rst_posx", ia.posx, 368);
    reset = 1'b0;
    tick(1);
    check("midrst_posx", ia.posx, 312);
    check("midrst_chr_a", ia.chr_a, 0);
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_rst_nostep", ia.posx, 312);
    frame();
    check("post_rst_step", ia.posx, 320);
    check("post_rst_chr_a", ia.chr_a, 1);
    set_a(0, 0, 0, 0);
    frame();

    for (int i = 0; i < 5; i++) begin
      ia.btn_chr = 1'b1;
      tick(5);
      check($sformatf("chr_%0d", i), ia.chr, 32'(chr_exp[i]));
      ia.btn_chr = 1'b0;
      tick(5);
    end

    for (int i = 0; i < 8; i++) begin
      ia.btn_col = 1'b1;
      tick(5);
      check($sformatf("rgb_%0d", i), ia.rgb, 32'(rgb_exp[i]));
      ia.btn_col = 1'b0;
      tick(5);
    end

    ia.blink_en = 1'b1;
    for (int f = 1; f <= 90; f++) begin
      frame();
      if (f == 29) check("blink_f29", ia.blink, 1);
      if (f == 30) check("blink_f30", ia.blink, 0);
      if (f == 59) check("blink_f59", ia.blink, 0);
      if (f == 60) check("blink_f60", ia.blink, 1);
      if (f == 90) check("blink_f90", ia.blink, 0);
    end
    ia.blink_en = 1'b0;
    tick(1);
    check("blink_drop", ia.blink, 1);

    // boundary instance: x starts at 4, y at 456
    check("b_init_posx", ib.posx, 4);
    check("b_init_posy", ib.posy, 456);
    set_b(0, 1, 1, 0);
    frame();
`ifdef CURSOR_WRAP_EN
    check("b_left_edge", ib.posx, 632);
`else
    check("b_left_edge", ib.posx, 0);
`endif
    check("b_down_exact", ib.posy, 464);
    set_b(0, 0, 0, 0);
    frame();
    set_b(0, 1, 1, 0);
    frame();
`ifdef CURSOR_WRAP_EN
    check("b_left_again", ib.posx, 624);
    check("b_down_over", ib.posy, 0);
`else
    check("b_left_again", ib.posx, 0);
    check("b_down_over", ib.posy, 464);
`endif
    set_b(0, 0, 0, 0);
    frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
